imm_gen_pipe: RTL and testbench

- Registered, parametrised immediate generator for the decode/execute boundary of the pipelined core.
- Extracts and sign- or zero-extends the immediate of a RISC-V instruction to XLEN bits, selected by a type code.
- Carries the immediate and a sideband tag through a one-stage output register with a valid/ready handshake.
- A one-entry skid buffer keeps in_ready registered.
- Supports flush, and flags unsupported type codes.

---
 rtl/imm_gen_pipe.sv | 114 +++++++++++
 tb/tb_imm_gen_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a registered output stage and a one-entry skid buffer.
// Output and skid entries both carry {valid, imm, illegal, tag}.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int unsigned IMM_W = XLEN;

  typedef struct packed {
    logic             valid;
    logic [IMM_W-1:0] imm;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t o_q, o_d;
  entry_t k_q, k_d;
  entry_t in_entry;

  logic [IMM_W-1:0] gen_imm;
  logic             gen_illegal;
  logic             accept;
  logic             fire;

  // Immediate extraction; every type code assigns a value
  always_comb begin
    gen_imm     = '0;
    gen_illegal = 1'b0;
    case (in_type)
      3'b000: gen_imm = IMM_W'($signed(in_inst[31:20]));
      3'b001: gen_imm = IMM_W'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                        in_inst[30:21], 1'b0}));
      3'b010: gen_imm = IMM_W'($signed({in_inst[31:12], 12'b0}));
      3'b011: gen_imm = IMM_W'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                        in_inst[11:8], 1'b0}));
      3'b100: gen_imm = IMM_W'($signed({in_inst[31:25], in_inst[11:7]}));
      3'b101: gen_imm = IMM_W'(in_inst[19:15]);
      3'b110: begin
        if (IMM_W == 64) gen_imm = IMM_W'(in_inst[25:20]);
        else             gen_imm = IMM_W'(in_inst[24:20]);
      end
      default: begin
        gen_imm     = '0;
        gen_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    in_entry.valid   = 1'b1;
    in_entry.imm     = gen_imm;
    in_entry.illegal = gen_illegal;
    in_entry.tag     = in_tag;
  end

  assign accept = in_valid && in_ready && !flush;
  assign fire   = o_q.valid && out_ready;

  // Next-state: flush, then refill O (skid first to keep order), then park in K
  always_comb begin
    o_d = o_q;
    k_d = k_q;
    if (flush) begin
      o_d.valid = 1'b0;
      k_d.valid = 1'b0;
    end else if (!o_q.valid || fire) begin
      if (k_q.valid) begin
        o_d       = k_q;
        k_d.valid = 1'b0;
        if (accept) k_d = in_entry;
      end else if (accept) begin
        o_d = in_entry;
      end else begin
        o_d.valid = 1'b0;
      end
    end else if (accept) begin
      k_d = in_entry;
    end
  end

  // in_ready is kept as its own flop mirroring !K.valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q      <= '0;
      k_q      <= '0;
      in_ready <= 1'b1;
    end else begin
      o_q      <= o_d;
      k_q      <= k_d;
      in_ready <= !k_d.valid;
    end
  end

  assign out_valid   = o_q.valid;
  assign out_imm     = o_q.imm;
  assign out_tag     = o_q.tag;
  assign out_illegal = o_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus lines.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] inst = '0;
  logic [2:0]  typ = '0;
  logic [7:0]  tag = '0;
  logic        v32 = 1'b0, v64 = 1'b0;

  logic        rdy32, rdy64, ov32, ov64, il32, il64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [7:0]  tg32, tg64;

  exp_t q32[$];
  exp_t q64[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(v32), .in_ready(rdy32), .in_inst(inst), .in_type(typ), .in_tag(tag),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_tag(tg32),
    .out_illegal(il32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(v64), .in_ready(rdy64), .in_inst(inst), .in_type(typ), .in_tag(tag),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_tag(tg64),
    .out_illegal(il64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: compare presented beat against the queue head; pop on fire
  always @(negedge clk) begin
    if (rst_n && ov32) begin
      if (q32.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL x32 unexpected beat: tag 0x%0h", tg32);
      end else begin
        chk("x32 imm", 64'(imm32), 64'(q32[0].imm[31:0]));
        chk("x32 tag", 64'(tg32), 64'(q32[0].tag));
        chk("x32 illegal", 64'(il32), 64'(q32[0].ill));
        if (out_ready) void'(q32.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov64) begin
      if (q64.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL x64 unexpected beat: tag 0x%0h", tg64);
      end else begin
        chk("x64 imm", imm64, q64[0].imm);
        chk("x64 tag", 64'(tg64), 64'(q64[0].tag));
        chk("x64 illegal", 64'(il64), 64'(q64[0].ill));
        if (out_ready) void'(q64.pop_front());
      end
    end
  end

  // Drive one beat; waits (bounded) for in_ready, pushes expectation at acceptance
  task automatic send(input bit w64, input logic [2:0] t, input logic [31:0] i,
                      input logic [7:0] g, input logic [63:0] e_imm, input logic e_ill);
    exp_t e;
    bit   done = 1'b0;
    typ = t; inst = i; tag = g;
    e.imm = e_imm; e.ill = e_ill; e.tag = g;
    if (w64) v64 = 1'b1; else v32 = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      if ((w64 ? rdy64 : rdy32) && !flush) begin
        if (w64) q64.push_back(e); else q32.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL send timeout: tag 0x%0h never accepted", g);
    end
  endtask

  task automatic idle();
    v32 = 1'b0; v64 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL drain timeout: %0d/%0d beats outstanding", q32.size(), q64.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(ov32), 64'd0);
    chk("reset in_ready", 64'(rdy32), 64'd1);
    chk("reset out_imm", 64'(imm32), 64'd0);
    chk("reset out_tag", 64'(tg32), 64'd0);
    chk("reset out_illegal", 64'(il32), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode sweep, XLEN=32, single beat latency first
    send(0, 3'b000, 32'hFFF00093, 8'h10, 64'hFFFFFFFF, 1'b0);
    idle();
    chk("latency out_valid", 64'(ov32), 64'd1);
    chk("latency out_imm", 64'(imm32), 64'hFFFFFFFF);
    send(0, 3'b010, 32'h123452B7, 8'h11, 64'h12345000, 1'b0);
    send(0, 3'b011, 32'hFE000EE3, 8'h12, 64'hFFFFFFFC, 1'b0);
    send(0, 3'b100, 32'h00112623, 8'h13, 64'h0000000C, 1'b0);
    send(0, 3'b001, 32'h800000EF, 8'h14, 64'hFFF00000, 1'b0);
    send(0, 3'b101, 32'h000FD073, 8'h15, 64'h1F, 1'b0);
    send(0, 3'b110, 32'h03F01013, 8'h16, 64'h1F, 1'b0);
    send(0, 3'b111, 32'hFFFFFFFF, 8'h17, 64'h0, 1'b1);
    send(0, 3'b000, 32'h00100093, 8'h18, 64'h1, 1'b0);
    idle();
    drain();

    // XLEN=64
    send(1, 3'b010, 32'h800002B7, 8'h20, 64'hFFFFFFFF80000000, 1'b0);
    send(1, 3'b110, 32'h03F01013, 8'h21, 64'h3F, 1'b0);
    send(1, 3'b101, 32'h000FD073, 8'h22, 64'h1F, 1'b0);
    send(1, 3'b000, 32'hFFF00093, 8'h23, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    send(1, 3'b111, 32'h00000013, 8'h24, 64'h0, 1'b1);
    send(1, 3'b100, 32'hFE112E23, 8'h25, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    idle();
    drain();

    // Backpressure: tags 1..4 with consumer stalled
    out_ready = 1'b0;
    send(0, 3'b000, 32'h00100093, 8'd1, 64'h1, 1'b0);
    chk("bp in_ready after 1st", 64'(rdy32), 64'd1);
    send(0, 3'b000, 32'h00200093, 8'd2, 64'h2, 1'b0);
    chk("bp in_ready after 2nd", 64'(rdy32), 64'd0);
    fork
      begin
        send(0, 3'b000, 32'h00300093, 8'd3, 64'h3, 1'b0);
        send(0, 3'b000, 32'h00400093, 8'd4, 64'h4, 1'b0);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Flush with O and K full and a live input
    out_ready = 1'b0;
    send(0, 3'b000, 32'h00500093, 8'h31, 64'h5, 1'b0);
    send(0, 3'b000, 32'h00600093, 8'h32, 64'h6, 1'b0);
    typ = 3'b000; inst = 32'h00700093; tag = 8'h33; v32 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; idle();
    q32.delete();
    chk("flush out_valid", 64'(ov32), 64'd0);
    chk("flush in_ready", 64'(rdy32), 64'd1);
    out_ready = 1'b1;
    send(0, 3'b000, 32'h00800093, 8'h34, 64'h8, 1'b0);
    idle();
    drain();

    // Asynchronous reset mid-stream with O and K full
    out_ready = 1'b0;
    send(0, 3'b011, 32'hFE000EE3, 8'h41, 64'hFFFFFFFC, 1'b0);
    send(0, 3'b000, 32'hFFF00093, 8'h42, 64'hFFFFFFFF, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(ov32), 64'd0);
    chk("async rst in_ready", 64'(rdy32), 64'd1);
    chk("async rst out_imm", 64'(imm32), 64'd0);
    chk("async rst out_tag", 64'(tg32), 64'd0);
    q32.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(0, 3'b100, 32'h00112623, 8'h43, 64'hC, 1'b0);
    idle();
    drain();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
